// File: rtl/sys_multicon.sv
// System multi-controller: 64-bit register file with GPIO (synchronised inputs,
// rising-edge interrupt) and a prescaled 64-bit MTIME with per-channel compare interrupts.
module sys_multicon #(
  parameter int unsigned NUM_GPIO   = 8,
  parameter int unsigned NUM_TIMERS = 2,
  parameter logic [31:0] VERSION    = 32'h80FFFFFF,
  parameter logic [31:0] SHA        = 32'hdeadbeef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [6:0]            i_addr,
  input  logic [7:0]            i_be,
  input  logic [63:0]           i_wdata,
  output logic                  o_ack,
  output logic [63:0]           o_rdata,
  input  logic [NUM_GPIO-1:0]   i_gpio,
  output logic [NUM_GPIO-1:0]   o_gpio,
  output logic                  o_gpio_irq,
  output logic [NUM_TIMERS-1:0] o_timer_irq
);

  localparam logic [3:0] IDX_ID       = 4'd0;
  localparam logic [3:0] IDX_GPIO_OUT = 4'd1;
  localparam logic [3:0] IDX_GPIO_IN  = 4'd2;
  localparam logic [3:0] IDX_GPIO_IRQ = 4'd3;
  localparam logic [3:0] IDX_MTIME    = 4'd4;
  localparam logic [3:0] IDX_PRESCALE = 4'd5;
  localparam logic [3:0] IDX_IRQ_EN   = 4'd6;
  localparam logic [3:0] IDX_CMP_BASE = 4'd8;

  logic [3:0]  idx;
  logic        wr;
  logic        rd;
  logic [63:0] be_mask;
  logic        unused_addr_bits;

  assign idx              = i_addr[6:3];
  assign wr               = i_req & i_we;
  assign rd               = i_req & ~i_we;
  assign unused_addr_bits = ^i_addr[2:0];

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < 8; i++) begin
      be_mask[8*i +: 8] = {8{i_be[i]}};
    end
  end

  logic                  ack_q, ack_d;
  logic [63:0]           rdata_q, rdata_d;
  logic [NUM_GPIO-1:0]   gpio_out_q, gpio_out_d;
  logic [NUM_GPIO-1:0]   gpio_sync1_q;
  logic [NUM_GPIO-1:0]   gpio_sync2_q;
  logic [NUM_GPIO-1:0]   gpio_prev_q;
  logic [NUM_GPIO-1:0]   gpio_irq_q, gpio_irq_d;
  logic                  gpio_irq_out_q, gpio_irq_out_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [15:0]           presc_cnt_q, presc_cnt_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [NUM_TIMERS-1:0] irq_en_q, irq_en_d;
  logic [63:0]           mtimecmp_q [NUM_TIMERS];
  logic [63:0]           mtimecmp_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] timer_irq_q, timer_irq_d;

  logic [63:0]           rd_val;
  logic                  tick;
  logic [NUM_GPIO-1:0]   gpio_rise;
  logic [NUM_GPIO-1:0]   gpio_clr;

  // Read mux sees the registers as they stand in the request cycle.
  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_ID:       rd_val = {SHA, VERSION};
      IDX_GPIO_OUT: rd_val[NUM_GPIO-1:0] = gpio_out_q;
      IDX_GPIO_IN:  rd_val[NUM_GPIO-1:0] = gpio_sync2_q;
      IDX_GPIO_IRQ: rd_val[NUM_GPIO-1:0] = gpio_irq_q;
      IDX_MTIME:    rd_val = mtime_q;
      IDX_PRESCALE: rd_val[15:0] = prescale_q;
      IDX_IRQ_EN:   rd_val[NUM_TIMERS-1:0] = irq_en_q;
      default:      rd_val = '0;
    endcase
    for (int n = 0; n < NUM_TIMERS; n++) begin
      if (idx == IDX_CMP_BASE + 4'(n)) begin
        rd_val = mtimecmp_q[n];
      end
    end
  end

  always_comb begin
    ack_d   = i_req;
    rdata_d = rd ? rd_val : rdata_q;

    gpio_out_d = gpio_out_q;
    if (wr && idx == IDX_GPIO_OUT) begin
      gpio_out_d = (gpio_out_q & ~be_mask[NUM_GPIO-1:0])
                 | (i_wdata[NUM_GPIO-1:0] & be_mask[NUM_GPIO-1:0]);
    end

    // A fresh edge in the same cycle as a clear keeps the bit set.
    gpio_rise = gpio_sync2_q & ~gpio_prev_q;
    gpio_clr  = '0;
    if (wr && idx == IDX_GPIO_IRQ) begin
      gpio_clr = i_wdata[NUM_GPIO-1:0] & be_mask[NUM_GPIO-1:0];
    end
    gpio_irq_d     = (gpio_irq_q & ~gpio_clr) | gpio_rise;
    gpio_irq_out_d = |gpio_irq_q;

    tick        = (presc_cnt_q == prescale_q);
    presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;

    prescale_d = prescale_q;
    if (wr && idx == IDX_PRESCALE) begin
      prescale_d  = (prescale_q & ~be_mask[15:0]) | (i_wdata[15:0] & be_mask[15:0]);
      presc_cnt_d = 16'd0;
    end

    // Write beats the tick: unwritten bytes keep the pre-tick value.
    if (wr && idx == IDX_MTIME) begin
      mtime_d = (mtime_q & ~be_mask) | (i_wdata & be_mask);
    end

    irq_en_d = irq_en_q;
    if (wr && idx == IDX_IRQ_EN) begin
      irq_en_d = (irq_en_q & ~be_mask[NUM_TIMERS-1:0])
               | (i_wdata[NUM_TIMERS-1:0] & be_mask[NUM_TIMERS-1:0]);
    end

    for (int n = 0; n < NUM_TIMERS; n++) begin
      mtimecmp_d[n] = mtimecmp_q[n];
      if (wr && idx == IDX_CMP_BASE + 4'(n)) begin
        mtimecmp_d[n] = (mtimecmp_q[n] & ~be_mask) | (i_wdata & be_mask);
      end
      timer_irq_d[n] = irq_en_q[n] & (mtime_q >= mtimecmp_q[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      gpio_out_q     <= '0;
      gpio_sync1_q   <= '0;
      gpio_sync2_q   <= '0;
      gpio_prev_q    <= '0;
      gpio_irq_q     <= '0;
      gpio_irq_out_q <= 1'b0;
      mtime_q        <= '0;
      presc_cnt_q    <= '0;
      prescale_q     <= '0;
      irq_en_q       <= '0;
      timer_irq_q    <= '0;
      for (int n = 0; n < NUM_TIMERS; n++) begin
        mtimecmp_q[n] <= '1;
      end
    end else begin
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      gpio_out_q     <= gpio_out_d;
      gpio_sync1_q   <= i_gpio;
      gpio_sync2_q   <= gpio_sync1_q;
      gpio_prev_q    <= gpio_sync2_q;
      gpio_irq_q     <= gpio_irq_d;
      gpio_irq_out_q <= gpio_irq_out_d;
      mtime_q        <= mtime_d;
      presc_cnt_q    <= presc_cnt_d;
      prescale_q     <= prescale_d;
      irq_en_q       <= irq_en_d;
      timer_irq_q    <= timer_irq_d;
      for (int n = 0; n < NUM_TIMERS; n++) begin
        mtimecmp_q[n] <= mtimecmp_d[n];
      end
    end
  end

  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_gpio      = gpio_out_q;
  assign o_gpio_irq  = gpio_irq_out_q;
  assign o_timer_irq = timer_irq_q;

endmodule
